aes_filter_arbiter: RTL and testbench
=====================================

Name: aes_filter_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single AES address-filter channel between NUM_REQ bus requesters.
- Sits upstream of the AES filter block.
- Grants one requester at a time, drives the filter's address/valid/rd_wr inputs, and tracks the filter's ready/valid responses until the transaction completes.
- Routes responses back only to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 23, request address width; matches the filter address field.
- TIMEOUT_CYCLES, 64, cycles without progress before abort (only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request pending.
- req_rd_wr_i  in  NUM_REQ  per-requester direction: 1=write, 0=read.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies [k*ADDR_W +: ADDR_W].
- addr_o  out  ADDR_W  address to filter.
- req_addr_valid_o  out  1  request valid to filter.
- rd_wr_o  out  1  direction to filter.
- resp_addr_ready_i  in  1  filter address-ready.
- resp_w_ready_i  in  1  filter write-ready.
- resp_r_b_valid_i  in  1  filter read/write-response valid.
- grant_o  out  NUM_REQ  one-hot grant; all zero when idle.
- resp_addr_ready_o  out  NUM_REQ  routed address-ready.
- resp_w_ready_o  out  NUM_REQ  routed write-ready.
- resp_r_b_valid_o  out  NUM_REQ  routed response-valid.
- busy_o  out  1  transaction in flight.
- timeout_o  out  1  single-cycle abort pulse.

Behaviour:
- Reset values:
  - state IDLE.
  - grant_o, addr_o, rd_wr_o, req_addr_valid_o, busy_o, timeout_o all 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-transaction aborts immediately; no response is routed.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any req_valid_i bit is set, select the first set bit searching upward from last_grant+1, with modulo NUM_REQ wrap.
  - Register grant_o (one-hot), and latch that requester's addr and rd_wr into addr_o/rd_wr_o.
  - Go to ADDR. Latency is 1 cycle from req_valid_i to req_addr_valid_o.
- ADDR:
  - req_addr_valid_o=1 and busy_o=1.
  - On resp_addr_ready_i: if resp_r_b_valid_i is also high, go to IDLE (filter's blocked-read case).
  - Else, on resp_addr_ready_i: go to DATA if write, RESP if read.
  - req_addr_valid_o drops on the cycle after ready is seen.
- DATA (write only):
  - Wait for resp_w_ready_i.
  - If resp_r_b_valid_i is high in the same cycle, go to IDLE; otherwise go to RESP.
- RESP: wait for resp_r_b_valid_i, then go to IDLE.
- On every return to IDLE from completion or abort:
  - last_grant <= granted index.
  - grant_o, busy_o and req_addr_valid_o clear in that same transition.
- Response routing is combinational: resp_X_o = {NUM_REQ{resp_X_i}} & grant_o. Non-granted requesters always see 0.
- Responses arriving in IDLE are dropped.
- addr_o/rd_wr_o hold latched values for the whole transaction. Changes on req_addr_i or a deasserted req_valid_i during a transaction are ignored; the transaction runs to completion.
- Back-to-back operation: a new grant may be issued in the IDLE cycle directly after completion, so there is a minimum 1 idle cycle between transactions.
- Fairness: with all requesters permanently valid, grants rotate 0,1,2,3,0,… and no requester waits more than NUM_REQ-1 transactions.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES)-bit counter clears on entry to ADDR/DATA/RESP and on each state advance.
  - It increments every cycle otherwise.
  - On reaching TIMEOUT_CYCLES-1 in a waiting state, the FSM aborts to IDLE and timeout_o pulses 1 cycle.
  - last_grant updates as for completion; no routed response is generated.
- When undefined: no counter, the FSM waits indefinitely, and timeout_o is tied to 0.

Test Plan:
- Single read:
  - Stimulus: req_valid_i=4'b0100, addr 0x000100, rd_wr 0; filter returns ready at +2 cycles and r_b_valid at +4 cycles.
  - Required: grant_o=4'b0100 one cycle after request; addr_o=0x000100; resp_r_b_valid_o=4'b0100 for exactly 1 cycle; then IDLE with grant_o=0.
- Blocked read:
  - Stimulus: filter asserts ready and r_b_valid in the same cycle.
  - Required: FSM goes ADDR→IDLE directly; busy_o low next cycle.
- Write sequence:
  - Stimulus: addr 0x200030, rd_wr 1; filter gives ready, then w_ready next cycle, then r_b_valid next cycle.
  - Required: FSM traverses ADDR→DATA→RESP→IDLE; each routed pulse appears only on the granted bit.
- Round-robin:
  - Stimulus: all four requesters continuously valid for 8 transactions.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Then requester 2 drops mid-transaction: its transaction still completes.
- Reset mid-transaction:
  - Stimulus: assert reset low asynchronously while in DATA.
  - Required: all outputs 0 immediately; after release, requester 0 is granted first.
- Timeout (with AES_ARB_TIMEOUT_EN):
  - Stimulus: ready never asserted.
  - Required: timeout_o pulses at cycle 63 after entering ADDR; next grant goes to the next requester.

Source files
------------

// File: rtl/aes_filter_arbiter.sv
// ============================================================================
// Module   : aes_filter_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one AES address-filter
//            channel between NUM_REQ requesters. Optional abort timer is
//            enabled with the macro AES_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_filter_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_rd_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [ADDR_W-1:0]         addr_o,
    output logic                      req_addr_valid_o,
    output logic                      rd_wr_o,
    input  logic                      resp_addr_ready_i,
    input  logic                      resp_w_ready_i,
    input  logic                      resp_r_b_valid_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        resp_addr_ready_o,
    output logic [NUM_REQ-1:0]        resp_w_ready_o,
    output logic [NUM_REQ-1:0]        resp_r_b_valid_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    localparam logic [c_IDX_W-1:0] c_LAST_INIT = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_IDX_W+1:0] c_NUM_REQ_W = (c_IDX_W + 2)'(NUM_REQ);

    logic [1:0]               r_state;
    logic [NUM_REQ-1:0]       r_grant;
    logic [c_IDX_W-1:0]       r_grant_idx;
    logic [c_IDX_W-1:0]       r_last_grant;
    logic [ADDR_W-1:0]        r_addr;
    logic                     r_rd_wr;

    logic [1:0]               w_state_nxt;
    logic                     w_timeout;
    logic [2*NUM_REQ-1:0]     w_req_dbl;
    logic [NUM_REQ-1:0]       w_req_rot;
    logic [c_IDX_W:0]         w_start;
    logic [c_IDX_W:0]         w_offset;
    logic [c_IDX_W+1:0]       w_sum;
    logic                     w_any_req;
    logic [c_IDX_W-1:0]       w_sel_idx;
    logic [NUM_REQ-1:0]       w_sel_onehot;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic                     w_sel_rd_wr;

    // Rotate the request vector so bit 0 is the requester after last_grant;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    assign w_req_dbl = {req_valid_i, req_valid_i};
    assign w_start   = {1'b0, r_last_grant} + (c_IDX_W + 1)'(1);
    assign w_req_rot = NUM_REQ'(w_req_dbl >> w_start);

    always_comb begin
        w_offset  = '0;
        w_any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_offset  = (c_IDX_W + 1)'(k);
                w_any_req = 1'b1;
            end
        end
    end

    assign w_sum        = {1'b0, w_start} + {1'b0, w_offset};
    assign w_sel_idx    = c_IDX_W'((w_sum >= c_NUM_REQ_W) ? (w_sum - c_NUM_REQ_W) : w_sum);
    assign w_sel_onehot = NUM_REQ'(1) << w_sel_idx;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_rd_wr = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel_onehot[k]) begin
                w_sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_rd_wr = req_rd_wr_i[k];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = c_ST_ADDR;
                end
            end
            c_ST_ADDR: begin
                // Ready together with a response is the filter rejecting a read.
                if (resp_addr_ready_i) begin
                    if (resp_r_b_valid_i) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if (r_rd_wr) begin
                        w_state_nxt = c_ST_DATA;
                    end else begin
                        w_state_nxt = c_ST_RESP;
                    end
                end
            end
            c_ST_DATA: begin
                if (resp_w_ready_i) begin
                    w_state_nxt = resp_r_b_valid_i ? c_ST_IDLE : c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (resp_r_b_valid_i) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int                c_TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_progress;

    // Progress is any non-abort state change; it restarts the wait count.
    always_comb begin
        w_progress = 1'b0;
        case (r_state)
            c_ST_ADDR: w_progress = resp_addr_ready_i;
            c_ST_DATA: w_progress = resp_w_ready_i;
            c_ST_RESP: w_progress = resp_r_b_valid_i;
            default:   w_progress = 1'b0;
        endcase
    end

    assign w_timeout = (r_state != c_ST_IDLE) && !w_progress && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == c_ST_IDLE) || w_progress || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= c_LAST_INIT;
            r_addr       <= '0;
            r_rd_wr      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE) begin
                if (w_any_req) begin
                    r_grant     <= w_sel_onehot;
                    r_grant_idx <= w_sel_idx;
                    r_addr      <= w_sel_addr;
                    r_rd_wr     <= w_sel_rd_wr;
                end
            end else if (w_state_nxt == c_ST_IDLE) begin
                r_grant      <= '0;
                r_last_grant <= r_grant_idx;
            end
        end
    end

    assign addr_o            = r_addr;
    assign rd_wr_o           = r_rd_wr;
    assign grant_o           = r_grant;
    assign req_addr_valid_o  = (r_state == c_ST_ADDR);
    assign busy_o            = (r_state != c_ST_IDLE);
    assign timeout_o         = w_timeout;

    // Grant is zero in IDLE, so stray filter responses are dropped there.
    assign resp_addr_ready_o = {NUM_REQ{resp_addr_ready_i}} & r_grant;
    assign resp_w_ready_o    = {NUM_REQ{resp_w_ready_i}}    & r_grant;
    assign resp_r_b_valid_o  = {NUM_REQ{resp_r_b_valid_i}}  & r_grant;

endmodule

`default_nettype wire

// File: tb/tb_aes_filter_arbiter.sv
// ============================================================================
// Module   : tb_aes_filter_arbiter
// Purpose  : Self-checking bench for aes_filter_arbiter; the timeout section
//            is compiled only when AES_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_filter_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int TC = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_rd_wr_i;
    logic [N*AW-1:0] req_addr_i;
    logic [AW-1:0]   addr_o;
    logic            req_addr_valid_o;
    logic            rd_wr_o;
    logic            resp_addr_ready_i;
    logic            resp_w_ready_i;
    logic            resp_r_b_valid_i;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    resp_addr_ready_o;
    logic [N-1:0]    resp_w_ready_o;
    logic [N-1:0]    resp_r_b_valid_o;
    logic            busy_o;
    logic            timeout_o;

    aes_filter_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid_i       (req_valid_i),
        .req_rd_wr_i       (req_rd_wr_i),
        .req_addr_i        (req_addr_i),
        .addr_o            (addr_o),
        .req_addr_valid_o  (req_addr_valid_o),
        .rd_wr_o           (rd_wr_o),
        .resp_addr_ready_i (resp_addr_ready_i),
        .resp_w_ready_i    (resp_w_ready_i),
        .resp_r_b_valid_i  (resp_r_b_valid_i),
        .grant_o           (grant_o),
        .resp_addr_ready_o (resp_addr_ready_o),
        .resp_w_ready_o    (resp_w_ready_o),
        .resp_r_b_valid_o  (resp_r_b_valid_o),
        .busy_o            (busy_o),
        .timeout_o         (timeout_o)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            model_last = N - 1;
    logic [AW-1:0] s_addr [N];
    logic [N-1:0]  s_rdwr;
    logic [N-1:0]  obs_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] pack_addr();
        logic [N*AW-1:0] r;
        for (int k = 0; k < N; k++) r[k*AW +: AW] = s_addr[k];
        return r;
    endfunction

    function automatic logic [N*AW-1:0] rand_bus();
        logic [N*AW-1:0] r;
        for (int k = 0; k < N; k++) r[k*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    // Round-robin reference: first requester at or after model_last+1.
    function automatic int pick(input logic [N-1:0] pat);
        for (int i = 1; i <= N; i++) begin
            if (pat[(model_last + i) % N]) return (model_last + i) % N;
        end
        return -1;
    endfunction

    task automatic drv(input logic ar, input logic wr, input logic bv);
        resp_addr_ready_i = ar;
        resp_w_ready_i    = wr;
        resp_r_b_valid_i  = bv;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc_chk(input string ph, input logic [N-1:0] eg, input logic ev, input logic eb);
        chk({ph, ".grant"}, 64'(grant_o), 64'(eg));
        chk({ph, ".addr_valid"}, 64'(req_addr_valid_o), 64'(ev));
        chk({ph, ".busy"}, 64'(busy_o), 64'(eb));
        chk({ph, ".r_addr_rdy"}, 64'(resp_addr_ready_o), 64'({N{resp_addr_ready_i}} & eg));
        chk({ph, ".r_w_rdy"}, 64'(resp_w_ready_o), 64'({N{resp_w_ready_i}} & eg));
        chk({ph, ".r_bvalid"}, 64'(resp_r_b_valid_o), 64'({N{resp_r_b_valid_i}} & eg));
        chk({ph, ".timeout"}, 64'(timeout_o), 64'(0));
    endtask

    // One IDLE cycle followed by a full transaction with the filter
    // behaviour described by the delay/blocking arguments.
    task automatic txn(input logic [N-1:0] pat, input logic [N-1:0] drop,
                       input bit blocked, input bit wblock,
                       input int da, input int dw, input int db);
        int            idx;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic          ew;
        @(negedge clk);
        req_valid_i = pat;
        req_rd_wr_i = s_rdwr;
        req_addr_i  = pack_addr();
        drv(rb(), rb(), rb());
        #1;
        cyc_chk("idle", '0, 1'b0, 1'b0);
        idx = pick(pat);
        if (idx < 0) return;
        eg      = '0;
        eg[idx] = 1'b1;
        ea      = s_addr[idx];
        ew      = s_rdwr[idx];
        for (int c = 0; c <= da; c++) begin
            @(negedge clk);
            req_valid_i = pat & ~drop;
            req_addr_i  = rand_bus();
            req_rd_wr_i = N'($urandom);
            if (c == da) drv(1'b1, rb(), blocked);
            else         drv(1'b0, rb(), rb());
            #1;
            if (c == 0) obs_grant = grant_o;
            cyc_chk("addr", eg, 1'b1, 1'b1);
            chk("addr.addr_o", 64'(addr_o), 64'(ea));
            chk("addr.rd_wr_o", 64'(rd_wr_o), 64'(ew));
        end
        if (!blocked && ew) begin
            for (int c = 0; c <= dw; c++) begin
                @(negedge clk);
                if (c == dw) drv(rb(), 1'b1, wblock);
                else         drv(rb(), 1'b0, rb());
                #1;
                cyc_chk("data", eg, 1'b0, 1'b1);
                chk("data.addr_o", 64'(addr_o), 64'(ea));
            end
        end
        if (!blocked && !(ew && wblock)) begin
            for (int c = 0; c <= db; c++) begin
                @(negedge clk);
                if (c == db) drv(rb(), rb(), 1'b1);
                else         drv(rb(), rb(), 1'b0);
                #1;
                cyc_chk("resp", eg, 1'b0, 1'b1);
                chk("resp.rd_wr_o", 64'(rd_wr_o), 64'(ew));
            end
        end
        model_last = idx;
    endtask

    initial begin
        reset       = 1'b0;
        req_valid_i = '0;
        req_rd_wr_i = '0;
        req_addr_i  = '0;
        obs_grant   = '0;
        drv(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) s_addr[k] = AW'($urandom);
        s_rdwr = '0;

        // Reset state, with filter responses forced high.
        repeat (2) @(negedge clk);
        #1;
        chk("rst.grant", 64'(grant_o), 64'(0));
        chk("rst.busy", 64'(busy_o), 64'(0));
        chk("rst.addr_o", 64'(addr_o), 64'(0));
        chk("rst.rd_wr_o", 64'(rd_wr_o), 64'(0));
        chk("rst.addr_valid", 64'(req_addr_valid_o), 64'(0));
        chk("rst.r_bvalid", 64'(resp_r_b_valid_o), 64'(0));
        chk("rst.timeout", 64'(timeout_o), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        drv(1'b0, 1'b0, 1'b0);

        // Round robin with everyone requesting.
        for (int i = 0; i < 8; i++) begin
            s_rdwr = N'($urandom);
            txn(4'b1111, '0, 1'b0, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            chk("rr.order", 64'(obs_grant), 64'(1 << (i % 4)));
        end
        txn(4'b1111, '0, 1'b0, 1'b0, 0, 0, 0);
        txn(4'b1111, '0, 1'b0, 1'b0, 0, 0, 0);
        s_rdwr = 4'b0100;
        txn(4'b1111, 4'b0100, 1'b0, 1'b0, 1, 1, 1);
        chk("drop.grant2", 64'(obs_grant), 64'(4'b0100));

        // Single read from requester 2.
        s_addr[2] = 23'h000100;
        s_rdwr    = 4'b0000;
        txn(4'b0100, '0, 1'b0, 1'b0, 2, 0, 1);
        chk("read.grant", 64'(obs_grant), 64'(4'b0100));

        // Blocked read: ready and response together.
        txn(4'b0001, '0, 1'b1, 1'b0, 1, 0, 0);
        chk("blocked.grant", 64'(obs_grant), 64'(4'b0001));

        // Write sequence from requester 3.
        s_addr[3] = 23'h200030;
        s_rdwr    = 4'b1000;
        txn(4'b1000, '0, 1'b0, 1'b0, 0, 0, 0);
        chk("write.grant", 64'(obs_grant), 64'(4'b1000));

        // Reset while in DATA.
        s_rdwr = 4'b1111;
        @(negedge clk);
        req_valid_i = 4'b0010;
        req_rd_wr_i = s_rdwr;
        req_addr_i  = pack_addr();
        drv(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b0);
        #1;
        chk("mid.busy", 64'(busy_o), 64'(1));
        chk("mid.grant", 64'(grant_o), 64'(4'b0010));
        #1;
        reset = 1'b0;
        drv(1'b1, 1'b1, 1'b1);
        #1;
        chk("arst.grant", 64'(grant_o), 64'(0));
        chk("arst.busy", 64'(busy_o), 64'(0));
        chk("arst.addr_o", 64'(addr_o), 64'(0));
        chk("arst.rd_wr_o", 64'(rd_wr_o), 64'(0));
        chk("arst.r_w_rdy", 64'(resp_w_ready_o), 64'(0));
        chk("arst.r_bvalid", 64'(resp_r_b_valid_o), 64'(0));
        @(negedge clk);
        reset       = 1'b1;
        req_valid_i = '0;
        drv(1'b0, 1'b0, 1'b0);
        model_last  = N - 1;
        txn(4'b1111, '0, 1'b0, 1'b0, 0, 0, 0);
        chk("arst.first", 64'(obs_grant), 64'(4'b0001));

        // Randomised traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) s_addr[k] = AW'($urandom);
            s_rdwr = N'($urandom);
            txn(N'($urandom), N'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
        end

`ifdef AES_ARB_TIMEOUT_EN
        begin
            int idx_t;
            @(negedge clk);
            req_valid_i = 4'b1111;
            drv(1'b0, 1'b0, 1'b0);
            idx_t = pick(4'b1111);
            for (int c = 0; c < TC; c++) begin
                @(negedge clk);
                drv(1'b0, 1'b0, 1'b0);
                #1;
                n_cmp++;
                assert (timeout_o === (c == TC - 1)) else begin
                    n_bad++;
                    $error("FAIL tmo.pulse: cycle %0d observed %0b", c, timeout_o);
                end
            end
            @(negedge clk);
            req_valid_i = '0;
            #1;
            chk("tmo.busy", 64'(busy_o), 64'(0));
            chk("tmo.timeout_low", 64'(timeout_o), 64'(0));
            model_last = idx_t;
            txn(4'b1111, '0, 1'b0, 1'b0, 0, 0, 0);
            chk("tmo.next", 64'(obs_grant), 64'(1 << ((idx_t + 1) % N)));
        end
`endif

        @(negedge clk);
        req_valid_i = '0;
        drv(1'b1, 1'b1, 1'b1);
        #1;
        cyc_chk("final", '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
